rotary_poller: RTL

//  Periodically sequences read strobes to NUM_ENC rotary_enc instances and

---
 rtl/rotary_poller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rotary_poller.sv
// Polls an array of rotary encoders on a fixed period. Each channel's delta goes into its
// own saturating accumulator. The host reads a channel over a req/ack port.
module rotary_poller #(
  parameter int NUM_ENC     = 4,
  parameter int POLL_CYCLES = 10000,
  parameter int READ_LAT    = 2,
  parameter int ACC_W       = 16,
  parameter int SEL_W       = $clog2(NUM_ENC + 1)
) (
  input  logic                   aclk,
  input  logic                   reset,
  output logic [NUM_ENC-1:0]     enc_rd,
  input  logic [8*NUM_ENC-1:0]   enc_delta,
  input  logic                   host_req,
  input  logic [SEL_W-1:0]       host_sel,
  input  logic                   host_clr,
  output logic                   host_ack,
  output logic [ACC_W-1:0]       host_data,
  output logic                   host_irq
);

  localparam int CH_W   = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
  localparam int TMR_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int WAIT_W = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_CAPTURE,
    S_NEXT
  } state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_ch;
  logic [WAIT_W-1:0]   r_wait;
  logic [TMR_W-1:0]    r_timer;
  logic [NUM_ENC-1:0]  r_enc_rd;
  logic [ACC_W-1:0]    r_acc [NUM_ENC];
  logic [NUM_ENC-1:0]  r_dirty;
  logic                r_irq;
  logic                r_ack;
  logic [ACC_W-1:0]    r_data;

  logic                w_tc;
  logic [7:0]          w_delta     [NUM_ENC];
  logic [ACC_W-1:0]    w_acc_next  [NUM_ENC];
  logic [NUM_ENC-1:0]  w_dirty_next;
  logic [NUM_ENC-1:0]  w_clr_hit;
  logic [NUM_ENC-1:0]  w_cap_hit;
  logic [ACC_W-1:0]    w_rd_val;

  assign w_tc = (r_timer == TMR_W'(POLL_CYCLES - 1));

  // Sweep sequencer; the period timer free-runs so sweep starts stay on a fixed grid.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_wait   <= '0;
      r_timer  <= '0;
      r_enc_rd <= '0;
    end else begin
      r_timer  <= w_tc ? '0 : r_timer + TMR_W'(1);
      r_enc_rd <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_tc) begin
            r_state  <= S_STROBE;
            r_ch     <= '0;
            r_enc_rd <= NUM_ENC'(1);
          end
        end
        S_STROBE: begin
          if (READ_LAT == 1) begin
            r_state <= S_CAPTURE;
          end else begin
            r_state <= S_WAIT;
            r_wait  <= WAIT_W'(READ_LAT - 1);
          end
        end
        S_WAIT: begin
          if (r_wait == WAIT_W'(1)) begin
            r_state <= S_CAPTURE;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        S_CAPTURE: begin
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_ch == CH_W'(NUM_ENC - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_STROBE;
            r_ch     <= r_ch + CH_W'(1);
            r_enc_rd <= NUM_ENC'(1) << (r_ch + CH_W'(1));
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENC; gi++) begin : g_ch
      logic [ACC_W:0]   w_base;
      logic [ACC_W:0]   w_sum;
      logic             w_ovf;
      logic [ACC_W-1:0] w_sat;

      assign w_delta[gi]   = enc_delta[8*gi +: 8];
      assign w_clr_hit[gi] = host_req && host_clr && (host_sel == SEL_W'(gi));
      assign w_cap_hit[gi] = (r_state == S_CAPTURE) && (r_ch == CH_W'(gi));

      // A clear that lands on the capture cycle restarts the channel from the new delta.
      // This way no movement is lost or counted twice.
      assign w_base = w_clr_hit[gi] ? '0 : {r_acc[gi][ACC_W-1], r_acc[gi]};
      assign w_sum  = w_base + {{(ACC_W-7){w_delta[gi][7]}}, w_delta[gi]};
      assign w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      assign w_sat  = !w_ovf      ? w_sum[ACC_W-1:0] :
                      w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                     {1'b0, {(ACC_W-1){1'b1}}};

      assign w_acc_next[gi]   = w_cap_hit[gi] ? w_sat :
                                w_clr_hit[gi] ? '0 : r_acc[gi];
      assign w_dirty_next[gi] = (w_cap_hit[gi] && (w_delta[gi] != 8'd0)) ? 1'b1 :
                                w_clr_hit[gi] ? 1'b0 : r_dirty[gi];
    end
  endgenerate

  // An out-of-range select falls through to zero.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_ENC; i++) begin
      if (host_sel == SEL_W'(i)) begin
        w_rd_val = r_acc[i];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENC; i++) begin
        r_acc[i] <= '0;
      end
      r_dirty <= '0;
      r_irq   <= 1'b0;
      r_ack   <= 1'b0;
      r_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_ENC; i++) begin
        r_acc[i] <= w_acc_next[i];
      end
      r_dirty <= w_dirty_next;
      r_irq   <= |r_dirty;
      r_ack   <= host_req;
      if (host_req) begin
        r_data <= w_rd_val;
      end
    end
  end

  assign enc_rd    = r_enc_rd;
  assign host_ack  = r_ack;
  assign host_data = r_data;
  assign host_irq  = r_irq;

endmodule
